// File: rtl/toy_mem_pkg.sv
// Shared types for the TOY data memory controller: FSM state encoding and the
// address-source select values.
package toy_mem_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} mem_state_e;
  localparam logic ASEL_IMM = 1'b0;
  localparam logic ASEL_REG = 1'b1;
endpackage

// File: rtl/toy_ram_1p.sv
// Single write port, synchronous read port word RAM. rdata only changes on re,
// so the last read result is held for the controller.
module toy_ram_1p #(
  parameter int DW    = 16,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_unused_addr;

  // Controller guarantees in-range addresses, so only the low index bits matter.
  assign w_unused_addr = ^{i_waddr, i_raddr};

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr[IW-1:0]] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr[IW-1:0]];
  end
endmodule

// File: rtl/toy_data_mem_ctrl.sv
// TOY CPU data memory controller: post-reset clear sweep, preload port, and a
// valid/ready CPU port with two address sources and range checking.
module toy_data_mem_ctrl
  import toy_mem_pkg::*;
#(
  parameter int              DW             = 16,
  parameter int              AW             = 12,
  parameter int              DEPTH          = 4096,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   INIT_VAL       = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic          i_req_asel,
  input  logic [AW-1:0] i_addr_imm,
  input  logic [AW-1:0] i_addr_reg,
  input  logic [DW-1:0] i_wdata_imm,
  input  logic [DW-1:0] i_wdata_reg,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_err,
  output logic          o_busy,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data
);
  // One extra bit so DEPTH == 2**AW is representable without truncation.
  localparam logic [AW:0] LIM  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  mem_state_e    r_state, w_state_nxt;
  logic [AW:0]   r_clr_cnt;
  logic          r_rd_valid, r_err, r_rd_ok;
  logic [AW-1:0] w_a, w_waddr;
  logic [DW-1:0] w_d, w_wdata, w_ram_rdata;
  logic          w_a_in, w_ld_in, w_accept, w_rd_acc, w_we;

  assign w_a         = (i_req_asel == ASEL_REG) ? i_addr_reg  : i_addr_imm;
  assign w_d         = (i_req_asel == ASEL_REG) ? i_wdata_reg : i_wdata_imm;
  assign w_a_in      = {1'b0, w_a} < LIM;
  assign w_ld_in     = {1'b0, i_ld_addr} < LIM;
  assign o_req_ready = (r_state == ST_RUN) && !i_ld_en;
  assign w_accept    = i_req_valid && o_req_ready && i_rst_n;
  assign w_rd_acc    = w_accept && !i_req_we;
  assign o_busy      = (r_state == ST_CLEAR);
  assign o_rd_valid  = r_rd_valid;
  assign o_err       = r_err;
  assign o_rd_data   = r_rd_ok ? w_ram_rdata : '0;

  // Write-port arbitration: clear sweep, then preload, then CPU.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = w_a;
    w_wdata     = w_d;
    case (r_state)
      ST_CLEAR: begin
        w_we    = i_rst_n;
        w_waddr = r_clr_cnt[AW-1:0];
        w_wdata = INIT_VAL;
        if (r_clr_cnt == LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_ld_en) begin
          w_we    = w_ld_in && i_rst_n;
          w_waddr = i_ld_addr;
          w_wdata = i_ld_data;
        end else begin
          w_we    = w_accept && i_req_we && w_a_in;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_rd_valid <= w_rd_acc;
      r_err      <= w_accept && !w_a_in;
      // Out-of-range reads force a zero result until the next accepted read.
      if (w_rd_acc) r_rd_ok <= w_a_in;
    end
  end

  toy_ram_1p #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_acc && w_a_in),
    .i_raddr (w_a),
    .o_rdata (w_ram_rdata)
  );
endmodule

// File: tb/tb_toy_data_mem_ctrl.sv
// Directed bench for toy_data_mem_ctrl with DEPTH=16: sweep, CPU read/write,
// preload arbitration, range errors, streaming reads and reset mid-sweep.
module tb_toy_data_mem_ctrl;
  localparam int DW = 16, AW = 12, DEPTH = 16;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we, req_asel;
  logic [AW-1:0] addr_imm, addr_reg, ld_addr;
  logic [DW-1:0] wdata_imm, wdata_reg, ld_data, rd_data;
  logic          rd_valid, err, busy, ld_en;

  int n_cmp = 0;
  int n_bad = 0;

  toy_data_mem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1),
                      .INIT_VAL(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_asel(req_asel), .i_addr_imm(addr_imm), .i_addr_reg(addr_reg),
    .i_wdata_imm(wdata_imm), .i_wdata_reg(wdata_reg), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_err(err), .o_busy(busy), .i_ld_en(ld_en),
    .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic idle;
    req_valid = 0; req_we = 0; req_asel = 0; ld_en = 0;
    addr_imm = '0; addr_reg = '0; wdata_imm = '0; wdata_reg = '0;
    ld_addr = '0; ld_data = '0;
  endtask

  task automatic drive_req(input logic we, input logic asel, input logic [AW-1:0] ai,
                           input logic [AW-1:0] ar, input logic [DW-1:0] di,
                           input logic [DW-1:0] dr);
    req_valid = 1; req_we = we; req_asel = asel;
    addr_imm = ai; addr_reg = ar; wdata_imm = di; wdata_reg = dr;
  endtask

  // Counts busy cycles after rst_n release; bounded so a stuck sweep still ends.
  task automatic count_sweep(input string tag);
    int bcnt = 0, rbad = 0, guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      bcnt++; guard++;
      if (req_ready !== 1'b0) rbad++;
      cyc;
    end
    n_cmp++; if (bcnt != DEPTH) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", tag, bcnt, DEPTH); end
    n_cmp++; if (rbad != 0) begin n_bad++; $display("FAIL %s_ready_in_clear: got %0d cycles want 0", tag, rbad); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after: got %b want 1", tag, req_ready); end
  endtask

  task automatic test_reset;
    idle; rst_n = 0;
    repeat (3) cyc;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    rst_n = 1;
    count_sweep("rst");
    drive_req(0, 0, 12'h005, 12'h000, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL rst_read5_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL rst_read5_data: got %h want 0000", rd_data); end
    cyc;
  endtask

  task automatic test_write_read;
    drive_req(1, 0, 12'h00A, 12'h003, 16'h1234, 16'hDEAD); cyc; idle;
    n_cmp++; if (rd_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wr_flags: got v=%b e=%b want 0 0", rd_valid, err); end
    drive_req(0, 1, 12'h005, 12'h00A, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL rd_a_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL rd_a_data: got %h want 1234", rd_data); end
    cyc;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL rd_data_hold: got %h want 1234", rd_data); end
    // reg-sourced write followed immediately by a read of the same word
    drive_req(1, 1, 12'h00A, 12'h007, 16'h0BAD, 16'hCAFE); cyc;
    drive_req(0, 0, 12'h007, 12'h00A, 16'h0, 16'h0); cyc;
    n_cmp++; if (rd_data !== 16'hCAFE) begin n_bad++; $display("FAIL raw_reg_data: got %h want CAFE", rd_data); end
    drive_req(0, 0, 12'h00A, 12'h000, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL imm_word_intact: got %h want 1234", rd_data); end
    cyc;
  endtask

  task automatic test_preload;
    drive_req(0, 0, 12'h003, 12'h000, 16'h0, 16'h0);
    ld_en = 1; ld_addr = 12'h003; ld_data = 16'hBEEF;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ld_blocks_ready: got %b want 0", req_ready); end
    cyc; ld_en = 0;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL ld_no_accept: got %b want 0", rd_valid); end
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready_back: got %b want 1", req_ready); end
    cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin n_bad++; $display("FAIL ld_retry: got v=%b d=%h want 1 BEEF", rd_valid, rd_data); end
    ld_en = 1; ld_addr = 12'h013; ld_data = 16'h1111; cyc; ld_en = 0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ld_oor_err: got %b want 0", err); end
    drive_req(0, 0, 12'h003, 12'h000, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_data !== 16'hBEEF) begin n_bad++; $display("FAIL ld_oor_dropped: got %h want BEEF", rd_data); end
    cyc;
  endtask

  task automatic test_out_of_range;
    drive_req(1, 0, 12'h020, 12'h000, 16'hFFFF, 16'h0); cyc; idle;
    n_cmp++; if (err !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL oor_wr: got e=%b v=%b want 1 0", err, rd_valid); end
    cyc;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_err_pulse: got %b want 0", err); end
    drive_req(0, 1, 12'h000, 12'h020, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0 || err !== 1'b1) begin n_bad++; $display("FAIL oor_rd: got v=%b d=%h e=%b want 1 0000 1", rd_valid, rd_data, err); end
    drive_req(0, 0, 12'h000, 12'h000, 16'h0, 16'h0); cyc;
    n_cmp++; if (rd_data !== 16'h0 || err !== 1'b0) begin n_bad++; $display("FAIL oor_addr0: got d=%h e=%b want 0000 0", rd_data, err); end
    drive_req(1, 0, 12'h00F, 12'h000, 16'hA5A5, 16'h0); cyc;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL edge_last_err: got %b want 0", err); end
    drive_req(1, 0, 12'h010, 12'h000, 16'h5A5A, 16'h0); cyc;
    drive_req(0, 0, 12'h000, 12'h000, 16'h0, 16'h0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL edge_depth_err: got %b want 1", err); end
    cyc;
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL edge_no_alias: got %h want 0000", rd_data); end
    drive_req(0, 0, 12'h00F, 12'h000, 16'h0, 16'h0); cyc;
    n_cmp++; if (rd_data !== 16'hA5A5) begin n_bad++; $display("FAIL edge_last_data: got %h want A5A5", rd_data); end
    drive_req(0, 0, 12'h100, 12'h000, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_data !== 16'h0 || err !== 1'b1 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL oor_high_bits: got v=%b d=%h e=%b want 1 0000 1", rd_valid, rd_data, err); end
    cyc;
  endtask

  task automatic test_back_to_back;
    ld_en = 1;
    ld_addr = 12'h001; ld_data = 16'h0011; cyc;
    ld_addr = 12'h002; ld_data = 16'h0022; cyc;
    ld_addr = 12'h003; ld_data = 16'h0033; cyc;
    ld_en = 0;
    drive_req(0, 0, 12'h001, 12'h000, 16'h0, 16'h0); cyc;
    drive_req(0, 1, 12'h000, 12'h002, 16'h0, 16'h0);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0011) begin n_bad++; $display("FAIL b2b_0: got v=%b d=%h want 1 0011", rd_valid, rd_data); end
    cyc;
    drive_req(0, 0, 12'h003, 12'h000, 16'h0, 16'h0);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0022) begin n_bad++; $display("FAIL b2b_1: got v=%b d=%h want 1 0022", rd_valid, rd_data); end
    cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0033) begin n_bad++; $display("FAIL b2b_2: got v=%b d=%h want 1 0033", rd_valid, rd_data); end
    cyc;
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 16'h0033) begin n_bad++; $display("FAIL b2b_end: got v=%b d=%h want 0 0033", rd_valid, rd_data); end
  endtask

  task automatic test_reset_mid_sweep;
    rst_n = 0; cyc; rst_n = 1;
    repeat (7) cyc;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    rst_n = 0; cyc;
    n_cmp++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy_rst: got b=%b r=%b want 1 0", busy, req_ready); end
    rst_n = 1;
    count_sweep("mid");
    drive_req(0, 0, 12'h003, 12'h000, 16'h0, 16'h0); cyc; idle;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin n_bad++; $display("FAIL mid_swept: got v=%b d=%h want 1 0000", rd_valid, rd_data); end
    cyc;
  endtask

  initial begin
    idle; rst_n = 0;
    test_reset;
    test_write_read;
    test_preload;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
